// File: rtl/instr_loader.sv
`default_nettype none
// ============================================================================
//  Module      : instr_loader
//  Description : Receives a program as a byte stream and writes it, one
//                32-bit word at a time, into instruction memory. The stream
//                is a 2-byte little-endian word count N followed by 4*N bytes.
//                Each word is sent little-endian. The CPU is held in reset
//                until a complete program has been written.
//  Ports       : clk_i        - system clock, rising edge
//                rst_i        - asynchronous active-high reset
//                start_i      - pulse that begins a new load (IDLE/DONE/ERR)
//                byte_valid_i - byte_i carries a program byte
//                byte_i       - program byte
//                byte_ready_o - loader accepts byte_i this cycle (HDR/DATA)
//                mem_we_o     - one-cycle instruction-memory write strobe
//                mem_addr_o   - byte address of the word being written
//                mem_data_o   - instruction word being written
//                cpu_rst_o    - low only once a program is fully loaded
//                done_o       - load completed successfully
//                err_o        - header word count exceeded DEPTH_WORDS
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_loader #(
    parameter int DEPTH_WORDS = 256
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic        byte_ready_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_data_o,
    output logic        cpu_rst_o,
    output logic        done_o,
    output logic        err_o
);

    localparam logic [31:0] c_depth_words = 32'(DEPTH_WORDS);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HDR   = 3'd1,
        DATA  = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4,
        ERR   = 3'd5
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [1:0]  r_byte_cnt;   // byte position within header or current word
    logic [15:0] r_word_idx;   // index of the next word to be written
    logic [15:0] r_n;          // word count taken from the header
    logic [31:0] r_asm;        // word assembly register
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_data;

    logic        w_ready;
    logic        w_accept;
    logic [15:0] w_hdr_n;
    logic        w_last_word;

    assign w_ready  = (r_state == HDR) || (r_state == DATA);
    assign w_accept = byte_valid_i && w_ready;

    // Full word count as it becomes known on the second header byte.
    assign w_hdr_n = {byte_i, r_n[7:0]};

    // Widened compare so the final-word test cannot be fooled by a carry.
    assign w_last_word = (({1'b0, r_word_idx} + 17'd1) == {1'b0, r_n});

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE, DONE, ERR: begin
                if (start_i) begin
                    w_next = HDR;
                end
            end
            HDR: begin
                if (w_accept && (r_byte_cnt == 2'd1)) begin
                    if (w_hdr_n == 16'd0) begin
                        w_next = DONE;
                    end else if ({16'd0, w_hdr_n} > c_depth_words) begin
                        w_next = ERR;
                    end else begin
                        w_next = DATA;
                    end
                end
            end
            DATA: begin
                if (w_accept && (r_byte_cnt == 2'd3)) begin
                    w_next = WRITE;
                end
            end
            WRITE: begin
                w_next = w_last_word ? DONE : DATA;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Counters, header capture, word assembly and memory-port registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_byte_cnt <= 2'd0;
            r_word_idx <= 16'd0;
            r_n        <= 16'd0;
            r_asm      <= 32'd0;
            r_mem_addr <= 32'd0;
            r_mem_data <= 32'd0;
        end else begin
            case (r_state)
                IDLE, DONE, ERR: begin
                    if (start_i) begin
                        r_byte_cnt <= 2'd0;
                        r_word_idx <= 16'd0;
                        r_n        <= 16'd0;
                    end
                end
                HDR: begin
                    if (w_accept) begin
                        if (r_byte_cnt == 2'd0) begin
                            r_n[7:0]   <= byte_i;
                            r_byte_cnt <= 2'd1;
                        end else begin
                            r_n[15:8]  <= byte_i;
                            r_byte_cnt <= 2'd0;
                        end
                    end
                end
                DATA: begin
                    if (w_accept) begin
                        r_asm[{r_byte_cnt, 3'b000} +: 8] <= byte_i;
                        // 2-bit counter wraps to 0 for the next word.
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        if (r_byte_cnt == 2'd3) begin
                            // Top lane comes straight from the bus since the
                            // assembly register has not captured it yet.
                            r_mem_data <= {byte_i, r_asm[23:0]};
                            r_mem_addr <= {14'd0, r_word_idx, 2'b00};
                        end
                    end
                end
                WRITE: begin
                    r_word_idx <= r_word_idx + 16'd1;
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign byte_ready_o = w_ready;
    assign mem_we_o     = (r_state == WRITE);
    assign mem_addr_o   = r_mem_addr;
    assign mem_data_o   = r_mem_data;
    assign cpu_rst_o    = (r_state != DONE);
    assign done_o       = (r_state == DONE);
    assign err_o        = (r_state == ERR);

endmodule
`default_nettype wire

// File: tb/tb_instr_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_loader
//  Description : Self-checking bench for instr_loader. A table of byte
//                streams with expected outcomes is replayed in a loop; the
//                bench derives the expected memory writes from each stream
//                and queues them, and every mem_we_o pulse is checked
//                against the head of that queue. Hand-written sequences
//                cover asynchronous reset mid-load and a full-depth load.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_loader;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic        byte_valid_i;
    logic [7:0]  byte_i;
    logic        byte_ready_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_data_o;
    logic        cpu_rst_o;
    logic        done_o;
    logic        err_o;

    instr_loader #(.DEPTH_WORDS(256)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .byte_valid_i (byte_valid_i),
        .byte_i       (byte_i),
        .byte_ready_o (byte_ready_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_data_o   (mem_data_o),
        .cpu_rst_o    (cpu_rst_o),
        .done_o       (done_o),
        .err_o        (err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [95:0] stream;    // byte k at bits [8k+7:8k]
        int          nbytes;
        bit          gaps;      // random byte_valid_i gaps
        int          start_at;  // byte index that also raises start_i, -1 none
        int          exp_lat;   // cycles from last accepted byte to DONE/ERR
        bit          exp_done;
        bit          exp_err;
    } vec_t;

    vec_t        vecs[6];
    logic [63:0] exp_q[$];      // {addr, data} of expected writes
    int          checks = 0;
    int          errors = 0;
    bit          prev_we = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one clock and sample just after the edge; any write strobe is
    // checked against the scoreboard here.
    task automatic step();
        logic [63:0] e;
        @(posedge clk_i);
        #1;
        if (mem_we_o) begin
            chk("ready_low_in_write", 64'(byte_ready_o), 64'd0);
            chk("we_single_cycle", 64'(prev_we), 64'd0);
            if (exp_q.size() == 0) begin
                chk("unexpected_write", {mem_addr_o, mem_data_o}, 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("write_addr", 64'(mem_addr_o), 64'(e[63:32]));
                chk("write_data", 64'(mem_data_o), 64'(e[31:0]));
            end
        end
        prev_we = mem_we_o;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int t;
        if (gaps) begin
            while ($urandom_range(0, 2) == 0) begin
                byte_valid_i = 1'b0;
                byte_i       = 8'($urandom);
                step();
            end
        end
        byte_valid_i = 1'b1;
        byte_i       = b;
        t = 0;
        while (!byte_ready_o && t < 20) begin
            step();
            t++;
        end
        if (t >= 20) chk("ready_timeout", 64'(t), 64'd0);
        step();
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        step();
        start_i = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"}, 64'(byte_ready_o), 64'd0);
        chk({tag, "_we"},    64'(mem_we_o),     64'd0);
        chk({tag, "_addr"},  64'(mem_addr_o),   64'd0);
        chk({tag, "_data"},  64'(mem_data_o),   64'd0);
        chk({tag, "_cpurst"},64'(cpu_rst_o),    64'd1);
        chk({tag, "_done"},  64'(done_o),       64'd0);
        chk({tag, "_err"},   64'(err_o),        64'd0);
    endtask

    // Replays one table entry; expected writes are derived from the stream.
    task automatic run_vec(input int vi);
        vec_t        v;
        logic [7:0]  b;
        logic [15:0] n;
        logic [31:0] w;
        int          d;
        v = vecs[vi];
        n = v.stream[15:0];
        pulse_start();
        chk($sformatf("v%0d_hdr_ready", vi), 64'(byte_ready_o), 64'd1);
        chk($sformatf("v%0d_hdr_flags", vi), {61'd0, err_o, done_o, cpu_rst_o}, 64'd1);
        for (int k = 0; k < v.nbytes; k++) begin
            b = v.stream[8*k +: 8];
            d = k - 2;
            if (d >= 0 && (d % 4) == 3 && n != 16'd0 && n <= 16'd256 && (d / 4) < int'(n)) begin
                w = v.stream[8*(k-3) +: 32];
                exp_q.push_back({32'(4 * (d / 4)), w});
            end
            if (k == v.start_at) start_i = 1'b1;
            send_byte(b, v.gaps);
            start_i = 1'b0;
        end
        byte_valid_i = 1'b0;
        repeat (v.exp_lat) step();
        chk($sformatf("v%0d_done", vi), 64'(done_o), 64'(v.exp_done));
        chk($sformatf("v%0d_err", vi), 64'(err_o), 64'(v.exp_err));
        chk($sformatf("v%0d_cpurst", vi), 64'(cpu_rst_o), 64'(!v.exp_done));
        chk($sformatf("v%0d_ready", vi), 64'(byte_ready_o), 64'd0);
        chk($sformatf("v%0d_pending", vi), 64'(exp_q.size()), 64'd0);
        // Terminal state must hold with no writes while bytes keep arriving.
        byte_valid_i = 1'b1;
        repeat (3) step();
        byte_valid_i = 1'b0;
        chk($sformatf("v%0d_hold", vi), {62'd0, done_o, err_o}, {62'd0, v.exp_done, v.exp_err});
    endtask

    logic [95:0] s_prog;

    initial begin
        s_prog = {8'h00, 8'hB0, 8'h05, 8'h93, 8'h00, 8'hA0, 8'h05, 8'h13, 8'h00, 8'h02};
        vecs[0] = '{stream: s_prog, nbytes: 10, gaps: 1'b0, start_at: -1, exp_lat: 1, exp_done: 1'b1, exp_err: 1'b0};
        vecs[1] = '{stream: s_prog, nbytes: 10, gaps: 1'b1, start_at: -1, exp_lat: 1, exp_done: 1'b1, exp_err: 1'b0};
        vecs[2] = '{stream: s_prog, nbytes: 10, gaps: 1'b0, start_at: 6,  exp_lat: 1, exp_done: 1'b1, exp_err: 1'b0};
        vecs[3] = '{stream: 96'h0101, nbytes: 2, gaps: 1'b0, start_at: -1, exp_lat: 0, exp_done: 1'b0, exp_err: 1'b1};
        vecs[4] = '{stream: 96'h0000, nbytes: 2, gaps: 1'b0, start_at: -1, exp_lat: 0, exp_done: 1'b1, exp_err: 1'b0};
        vecs[5] = '{stream: {8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00, 8'h01}, nbytes: 6, gaps: 1'b1,
                    start_at: -1, exp_lat: 1, exp_done: 1'b1, exp_err: 1'b0};

        rst_i        = 1'b1;
        start_i      = 1'b0;
        byte_valid_i = 1'b0;
        byte_i       = 8'h00;
        repeat (2) step();
        check_reset_outputs("reset");
        rst_i = 1'b0;

        // Without start_i the loader stays idle even with bytes offered.
        byte_valid_i = 1'b1;
        byte_i       = 8'h55;
        repeat (4) step();
        byte_valid_i = 1'b0;
        chk("idle_hold_ready", 64'(byte_ready_o), 64'd0);
        chk("idle_hold_cpurst", 64'(cpu_rst_o), 64'd1);

        for (int i = 0; i < 6; i++) run_vec(i);

        // Asynchronous reset between edges after the 6th data byte.
        pulse_start();
        for (int k = 0; k < 8; k++) begin
            if (k == 5) exp_q.push_back({32'h0, 32'h00A00513});
            send_byte(s_prog[8*k +: 8], 1'b0);
        end
        #2;
        rst_i = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        #1;
        rst_i = 1'b0;
        byte_valid_i = 1'b1;
        repeat (10) step();
        byte_valid_i = 1'b0;
        chk("async_rst_idle_ready", 64'(byte_ready_o), 64'd0);
        chk("async_rst_pending", 64'(exp_q.size()), 64'd0);

        // Full-depth load: N = DEPTH_WORDS is accepted and fills to 0x3FC.
        pulse_start();
        send_byte(8'h00, 1'b0);
        send_byte(8'h01, 1'b0);
        chk("full_not_err", 64'(err_o), 64'd0);
        for (int wi = 0; wi < 256; wi++) begin
            logic [31:0] word;
            word = 32'hC0DE_0000 | 32'(wi * 3);
            for (int ln = 0; ln < 4; ln++) begin
                if (ln == 3) exp_q.push_back({32'(4 * wi), word});
                send_byte(word[8*ln +: 8], 1'b0);
            end
        end
        byte_valid_i = 1'b0;
        step();
        chk("full_done", 64'(done_o), 64'd1);
        chk("full_pending", 64'(exp_q.size()), 64'd0);
        chk("full_last_addr", 64'(mem_addr_o), 64'h3FC);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
